// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the inter-stage pipeline register.
// Holds the default reset/flush PCs, MIPS exception codes, the NOP
// encoding and the fixed-width header carried by every stage boundary.
package pipe_stage_reg_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned EXC_W   = 5;

   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [PC_W-1:0] FLUSH_PC_DEF = 32'h0000_4180;

   // CP0 Cause.ExcCode values
   localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
   localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
   localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   // Fixed-width part of a pipeline slot (payload width is per instance)
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               bd;
      logic [EXC_W-1:0]   exc;
   } stage_hdr_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports: clk, reset (async, active-high), inc (count up one),
//        clr (return to zero, wins over inc), cnt (registered count).
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register (F/D, D/E, E/M, M/W).
// Carries PC, instruction, delay-slot flag, exception code and a generic
// payload with a valid bit. Per-edge action priority:
// reset > flush > bubble > hold (en=0) > load (en=1).
// Ports: clk, reset (async, active-high), en, bubble, flush,
//        valid_in/pc_in/instr_in/bd_in/exc_in/data_in (upstream slot),
//        matching *_out registered copies, stall_cnt (saturating hold count).
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned     DATA_W   = 64,
   parameter logic [31:0]     RESET_PC = RESET_PC_DEF,
   parameter logic [31:0]     FLUSH_PC = FLUSH_PC_DEF,
   parameter int unsigned     CNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              bubble,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       instr_in,
   input  logic              bd_in,
   input  logic [4:0]        exc_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid_out,
   output logic [31:0]       pc_out,
   output logic [31:0]       instr_out,
   output logic              bd_out,
   output logic [4:0]        exc_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_hdr_t        hdr_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              hold_c;

   // A cycle is a stall only when no higher-priority action applies
   assign hold_c = !flush && !bubble && !en;

   // Slot register: priority-encoded next-state selection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr_q.pc    <= RESET_PC;
         hdr_q.instr <= NOP_INSTR;
         hdr_q.bd    <= 1'b0;
         hdr_q.exc   <= EXC_INT;
         valid_q     <= 1'b0;
         data_q      <= '0;
      end else if (flush) begin
         hdr_q.pc    <= FLUSH_PC;
         hdr_q.instr <= NOP_INSTR;
         hdr_q.bd    <= 1'b0;
         hdr_q.exc   <= EXC_INT;
         valid_q     <= 1'b0;
         data_q      <= '0;
      end else if (bubble) begin
         // PC/BD survive so CP0 can form EPC for an interrupt on a bubble
         hdr_q.pc    <= pc_in;
         hdr_q.instr <= NOP_INSTR;
         hdr_q.bd    <= bd_in;
         hdr_q.exc   <= EXC_INT;
         valid_q     <= 1'b0;
         data_q      <= '0;
      end else if (en) begin
         hdr_q.pc    <= pc_in;
         hdr_q.instr <= instr_in;
         hdr_q.bd    <= bd_in;
         hdr_q.exc   <= exc_in;
         valid_q     <= valid_in;
         data_q      <= data_in;
      end
   end

   // Consecutive-hold counter for hazard debugging
   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hold_c),
      .clr   (!hold_c),
      .cnt   (stall_cnt)
   );

   assign valid_out = valid_q;
   assign pc_out    = hdr_q.pc;
   assign instr_out = hdr_q.instr;
   assign bd_out    = hdr_q.bd;
   assign exc_out   = hdr_q.exc;
   assign data_out  = data_q;

endmodule
